nes_pad_poller: RTL and testbench
=================================

// Module: nes_pad_poller
// PURPOSE
//  Polls N_PADS NES controllers in parallel and returns clean, active-high button words.
//  Generates the latch and shift-clock waveform for each pad and shifts in 8 serial bits.
//  Successor to the fixed two-pad left/right controller FSMs; pad count and timing are parameters.
//  Sits between the bidir pad pins and the paddle/game datapath.
// PARAMETERS
//  N_PADS        2       number of controllers polled simultaneously (1..8)
//  HALF_BIT_CYC  150     clk cycles per pad_clk phase (6 us at 25 MHz); must be >= 4
//  POLL_CYC      416667  clk cycles between scan starts (~60 Hz at 25 MHz); must be > 17*HALF_BIT_CYC+2
// PORTS
//  clk        in   1         system clock
//  reset      in   1         asynchronous, active-high reset
//  poll_en    in   1         1 = scans run on the poll timer; 0 = stay idle after the current scan
//  pad_data   in   N_PADS    serial data from each pad, active-low, asynchronous
//  pad_clk    out  N_PADS    shift clock to each pad; all bits identical
//  pad_latch  out  N_PADS    latch to each pad; all bits identical
//  buttons    out  8*N_PADS  pad p at [8p+7:8p]; bit 0..7 = A,B,Select,Start,Up,Down,Left,Right; 1 = pressed
//  valid      out  1         one-cycle strobe when a scan completes
// BEHAVIOUR
//  Reset (async): state=IDLE; pad_clk=0; pad_latch=0; buttons=0; valid=0; counters=0; sync flops=1.
//  pad_data passes through a 2-flop synchronizer per pad. Every sample uses the synchronized value.
//  Poll timer: counts 0..POLL_CYC-1 and wraps. At wrap with poll_en=1 in IDLE, go to LATCH.
//  FSM states: IDLE, LATCH, LOW, HIGH, DONE.
//   LATCH: pad_latch=1 for 2*HALF_BIT_CYC cycles, then go to LOW.
//   LOW: pad_clk=0 for HALF_BIT_CYC cycles. On the last cycle, sample bit[idx] = ~data.
//    If idx==7, go to DONE; otherwise idx++ and go to HIGH.
//   HIGH: pad_clk=1 for HALF_BIT_CYC cycles. The pad shifts on the rising edge. Then go to LOW.
//   DONE: one cycle. Load buttons from the shift registers, valid=1, then go to IDLE.
//  Scan length: 2H latch + 8H low + 7H high = 17*HALF_BIT_CYC cycles from LATCH entry to the last sample.
//   valid rises 1 cycle after the last sample.
//  Every pad is sampled in the same cycle. buttons only change in the DONE cycle and hold otherwise.
//  poll_en falling mid-scan: the scan completes normally, then the FSM stays in IDLE.
//   poll_en rising: the scan starts at the next timer wrap, with no immediate start.
//  A disconnected pad (data pulled high) reads 8'h00.
//  Reset asserted mid-scan: all outputs return to reset values immediately, and partial data is discarded.
//  The timer counts freely in every state, so the scan period is exactly POLL_CYC cycles.
// CONFIGURATION
//  NES_DEBOUNCE_EN defined: each pad keeps the raw word from its previous scan.
//   buttons[p] is loaded only when the new raw word equals the previous raw word.
//   valid still pulses on every scan. After reset a press needs 2 scans to appear.
//  NES_DEBOUNCE_EN undefined: buttons is loaded on every scan (1-scan latency), and there are no extra registers.
// STRUCTURE
//  nes_pkg: BTN_A..BTN_RIGHT bit-index localparams (0..7), state encoding localparams,
//   and the NES_BITS=8 constant. The game datapath shares it.
//  Sub-module nes_sync: 2-flop synchronizer with reset value 1, one instance per pad.
//  Everything else (timer, phase counter, 3-bit idx, per-pad shift registers) lives in this module.
// TESTING  (H=HALF_BIT_CYC=4, POLL_CYC=200, N_PADS=2)
//  Reset then release, pad models idle high -> pad_latch rises at timer wrap.
//   pad_latch is high for 8 cycles; exactly 7 pad_clk pulses of 4 high / 4 low; valid at cycle 69; buttons=16'h0000.
//  Pad0 drives A+Right (bits 0,7 low), pad1 drives Start -> buttons=16'h0881 at valid.
//  Checkers: pad_clk and pad_latch never high together; period = 200 cycles.
//  poll_en=0 asserted at the 3rd LOW phase -> that scan completes with valid=1.
//   No further pad_latch for 3 periods. Re-enable -> next latch at the following timer wrap.
//  Reset pulsed during HIGH of bit 4 -> pad_clk, pad_latch, buttons and valid go to 0 in the same cycle, asynchronously.
//   The next scan is a clean full 8-bit read.
//  pad_data toggled asynchronously (non-integer period) -> no X in buttons; sampled values match the model after sync delay.
//  With NES_DEBOUNCE_EN: pad0 shows A for 1 scan only -> buttons stays 16'h0000.
//   A held for 2 scans -> buttons[0]=1 at the 2nd valid.
//   Without the macro -> buttons[0]=1 at the 1st valid.

Source files
------------

// File: rtl/nes_pkg.sv
// Shared NES controller definitions: button bit positions, FSM encodings and word width.
// Used by the pad poller and by the game datapath.
package nes_pkg;

   localparam int NES_BITS = 8;

   localparam int BTN_A      = 0;
   localparam int BTN_B      = 1;
   localparam int BTN_SELECT = 2;
   localparam int BTN_START  = 3;
   localparam int BTN_UP     = 4;
   localparam int BTN_DOWN   = 5;
   localparam int BTN_LEFT   = 6;
   localparam int BTN_RIGHT  = 7;

   localparam logic [2:0] ST_IDLE_ENC  = 3'd0;
   localparam logic [2:0] ST_LATCH_ENC = 3'd1;
   localparam logic [2:0] ST_LOW_ENC   = 3'd2;
   localparam logic [2:0] ST_HIGH_ENC  = 3'd3;
   localparam logic [2:0] ST_DONE_ENC  = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE  = ST_IDLE_ENC,
      ST_LATCH = ST_LATCH_ENC,
      ST_LOW   = ST_LOW_ENC,
      ST_HIGH  = ST_HIGH_ENC,
      ST_DONE  = ST_DONE_ENC
   } nes_state_e;

   function automatic logic [NES_BITS-1:0] set_bit(
      input logic [NES_BITS-1:0] word,
      input logic [2:0]          pos,
      input logic                val
   );
      logic [NES_BITS-1:0] res;
      res      = word;
      res[pos] = val;
      return res;
   endfunction

endpackage

// File: rtl/nes_sync.sv
// Two-flop synchronizer for one pad data line; resets to 1 (pad idle level).
module nes_sync (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);
   logic meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/nes_pad_poller.sv
// Polls N_PADS NES controllers in parallel and returns active-high button words.
// Optional NES_DEBOUNCE_EN: a pad's word only updates when two consecutive scans agree.
//
// state    | meaning
// ST_IDLE  | waiting for poll timer wrap with poll_en set
// ST_LATCH | pad_latch high for 2*HALF_BIT_CYC cycles
// ST_LOW   | pad_clk low; bit idx sampled on the last cycle
// ST_HIGH  | pad_clk high; pads shift on the rising edge
// ST_DONE  | one cycle, valid strobe with buttons freshly loaded
module nes_pad_poller
   import nes_pkg::*;
#(
   parameter int N_PADS       = 2,
   parameter int HALF_BIT_CYC = 150,
   parameter int POLL_CYC     = 416667
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       poll_en,
   input  logic [N_PADS-1:0]          pad_data,
   output logic [N_PADS-1:0]          pad_clk,
   output logic [N_PADS-1:0]          pad_latch,
   output logic [NES_BITS*N_PADS-1:0] buttons,
   output logic                       valid
);
   localparam int TMR_W = $clog2(POLL_CYC);
   localparam int PH_W  = $clog2(2*HALF_BIT_CYC);
   localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(POLL_CYC - 1);
   localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);
   localparam logic [PH_W-1:0]  LATCH_LOAD = PH_W'(2*HALF_BIT_CYC - 1);
   localparam logic [PH_W-1:0]  HALF_LOAD  = PH_W'(HALF_BIT_CYC - 1);
   localparam logic [PH_W-1:0]  PH_ONE     = PH_W'(1);
   localparam logic [2:0]       LAST_IDX   = 3'(NES_BITS - 1);

   nes_state_e       state, next_state;
   logic [TMR_W-1:0] tmr;
   logic [PH_W-1:0]  ph_cnt, ph_next;
   logic [2:0]       idx, idx_next;
   logic             tmr_wrap, ph_tc, sample, scan_end;
   logic             clk_q, latch_q;

   assign tmr_wrap = (tmr == TMR_LAST);
   assign ph_tc    = (ph_cnt == '0);
   assign scan_end = sample && (idx == LAST_IDX);

   // Free-running poll timer; independent of the FSM so the scan period is exact.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)         tmr <= '0;
      else if (tmr_wrap) tmr <= '0;
      else               tmr <= tmr + TMR_ONE;
   end

   always_comb begin
      next_state = state;
      ph_next    = ph_tc ? ph_cnt : (ph_cnt - PH_ONE);
      idx_next   = idx;
      sample     = 1'b0;
      unique case (state)
         ST_IDLE: begin
            idx_next = '0;
            if (tmr_wrap && poll_en) begin
               next_state = ST_LATCH;
               ph_next    = LATCH_LOAD;
            end
         end
         ST_LATCH: begin
            if (ph_tc) begin
               next_state = ST_LOW;
               ph_next    = HALF_LOAD;
            end
         end
         ST_LOW: begin
            if (ph_tc) begin
               sample = 1'b1;
               if (idx == LAST_IDX) begin
                  next_state = ST_DONE;
               end else begin
                  next_state = ST_HIGH;
                  ph_next    = HALF_LOAD;
                  idx_next   = idx + 3'd1;
               end
            end
         end
         ST_HIGH: begin
            if (ph_tc) begin
               next_state = ST_LOW;
               ph_next    = HALF_LOAD;
            end
         end
         ST_DONE: begin
            next_state = ST_IDLE;
            idx_next   = '0;
         end
         default: next_state = ST_IDLE;
      endcase
   end

   // Pin outputs are registered from next_state so they are glitch-free and aligned with state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= ST_IDLE;
         ph_cnt  <= '0;
         idx     <= '0;
         clk_q   <= 1'b0;
         latch_q <= 1'b0;
         valid   <= 1'b0;
      end else begin
         state   <= next_state;
         ph_cnt  <= ph_next;
         idx     <= idx_next;
         clk_q   <= (next_state == ST_HIGH);
         latch_q <= (next_state == ST_LATCH);
         valid   <= (next_state == ST_DONE);
      end
   end

   assign pad_clk   = {N_PADS{clk_q}};
   assign pad_latch = {N_PADS{latch_q}};

   for (genvar p = 0; p < N_PADS; p++) begin : g_pad
      logic                sync_q;
      logic [NES_BITS-1:0] sr, raw_next, btn_q;

      nes_sync u_sync (
         .clk (clk),
         .rst (reset),
         .d   (pad_data[p]),
         .q   (sync_q)
      );

      // Pad data is active-low; the final bit is merged here so buttons is ready in ST_DONE.
      assign raw_next = set_bit(sr, idx, ~sync_q);

      always_ff @(posedge clk or posedge reset) begin
         if (reset)       sr <= '0;
         else if (sample) sr <= raw_next;
      end

`ifdef NES_DEBOUNCE_EN
      logic [NES_BITS-1:0] prev_raw;

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            prev_raw <= '0;
            btn_q    <= '0;
         end else if (scan_end) begin
            prev_raw <= raw_next;
            if (raw_next == prev_raw) btn_q <= raw_next;
         end
      end
`else
      always_ff @(posedge clk or posedge reset) begin
         if (reset)         btn_q <= '0;
         else if (scan_end) btn_q <= raw_next;
      end
`endif

      assign buttons[NES_BITS*p +: NES_BITS] = btn_q;
   end

endmodule

// File: tb/tb_nes_pad_poller.sv
// Directed bench for nes_pad_poller (H=4, POLL_CYC=200, 2 pads) with a 4021-style pad model.
module tb_nes_pad_poller;
   import nes_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        poll_en = 1'b1;
   logic [1:0]  pad_data;
   logic [1:0]  pad_clk, pad_latch;
   logic [15:0] buttons;
   logic        valid;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   logic [7:0] btn0 = 8'h00, btn1 = 8'h00;
   int         ptr = 0;
   logic [1:0] mdl = 2'b11;
   logic       toggle_en = 1'b0;
   logic       tog = 1'b1;

   nes_pad_poller #(.N_PADS(2), .HALF_BIT_CYC(4), .POLL_CYC(200)) dut (
      .clk       (clk),
      .reset     (reset),
      .poll_en   (poll_en),
      .pad_data  (pad_data),
      .pad_clk   (pad_clk),
      .pad_latch (pad_latch),
      .buttons   (buttons),
      .valid     (valid)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Pad model: latch loads, rising pad_clk shifts; output changes a few time units later.
   always @(posedge pad_clk[0] or posedge pad_latch[0]) begin
      if (pad_latch[0]) ptr = 0;
      else              ptr = ptr + 1;
   end

   always begin
      @(ptr or btn0 or btn1);
      #3;
      mdl[0] = (ptr < 8) ? ~btn0[ptr] : 1'b0;
      mdl[1] = (ptr < 8) ? ~btn1[ptr] : 1'b0;
   end

   always begin
      #37;
      tog = ~tog;
   end

   assign pad_data = {toggle_en ? tog : mdl[1], mdl[0]};

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) check_val("clk_latch_overlap", 32'(pad_clk[0] & pad_latch[0]), 32'd0);

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_scan(input string tag, output logic [15:0] word, output int rise);
      int n, idx, latch_len, clk_hi, pulses, run, max_run;
      logic prev_clk;
      n = 0;
      while (pad_latch[0] !== 1'b1 && n < 450) begin step(); n++; end
      check_val({tag, " latch_start"}, 32'(n < 450), 32'd1);
      rise = cyc;
      idx = 1; latch_len = 0; clk_hi = 0; pulses = 0; run = 0; max_run = 0; prev_clk = 1'b0;
      while (valid !== 1'b1 && idx < 120) begin
         if (pad_latch[0]) latch_len++;
         if (pad_clk[0]) begin
            clk_hi++; run++;
            if (!prev_clk) pulses++;
            if (run > max_run) max_run = run;
         end else begin
            run = 0;
         end
         prev_clk = pad_clk[0];
         step();
         idx++;
      end
      check_val({tag, " valid_cycle"}, idx, 32'd69);
      check_val({tag, " latch_len"}, latch_len, 32'd8);
      check_val({tag, " clk_pulses"}, pulses, 32'd7);
      check_val({tag, " clk_high_total"}, clk_hi, 32'd28);
      check_val({tag, " clk_high_width"}, max_run, 32'd4);
      word = buttons;
      step();
      check_val({tag, " valid_one_cycle"}, 32'(valid), 32'd0);
   endtask

   initial begin
      logic [15:0] w;
      int r_prev, r_cur, rl, n, cnt, rises;
      logic prev;

      repeat (3) step();
      check_val("reset pad_clk", 32'(pad_clk), 32'd0);
      check_val("reset pad_latch", 32'(pad_latch), 32'd0);
      check_val("reset buttons", 32'(buttons), 32'd0);
      check_val("reset valid", 32'(valid), 32'd0);
      @(negedge clk) reset = 1'b0;

      run_scan("idle", w, r_prev);
      check_val("idle buttons", 32'(w), 32'h0000);

      // A+Right on pad0, Start on pad1
      btn0 = 8'h81; btn1 = 8'h08;
`ifdef NES_DEBOUNCE_EN
      run_scan("pat_first", w, r_cur);
      check_val("pat debounce hold", 32'(w), 32'h0000);
      r_prev = r_cur;
`endif
      run_scan("pat", w, r_cur);
      check_val("pat buttons", 32'(w), 32'h0881);
      check_val("poll period", r_cur - r_prev, 32'd200);

      btn0 = 8'h5A; btn1 = 8'hC3;
`ifdef NES_DEBOUNCE_EN
      run_scan("skew_first", w, r_cur);
`endif
      run_scan("skew", w, r_cur);
      check_val("skew buttons", 32'(w), 32'hC35A);

      // pad1 toggles freely, asynchronous to clk
      btn0 = 8'h3C; toggle_en = 1'b1;
`ifdef NES_DEBOUNCE_EN
      run_scan("toggle_first", w, r_cur);
`endif
      run_scan("toggle", w, r_cur);
      check_val("toggle no_x", 32'($isunknown(w)), 32'd0);
      check_val("toggle pad0", 32'(w[7:0]), 32'h3C);
      toggle_en = 1'b0;

      // poll_en drops in the 3rd LOW phase
      btn0 = 8'h81; btn1 = 8'h08;
      n = 0;
      while (pad_latch[0] !== 1'b1 && n < 450) begin step(); n++; end
      check_val("poll latch_start", 32'(n < 450), 32'd1);
      rl = cyc;
      cnt = 0; prev = pad_clk[0];
      while (cnt < 2 && n < 600) begin step(); n++; if (!pad_clk[0] && prev) cnt++; prev = pad_clk[0]; end
      poll_en = 1'b0;
      n = 0;
      while (valid !== 1'b1 && n < 100) begin step(); n++; end
      check_val("poll scan completes", 32'(valid), 32'd1);
      rises = 0; prev = pad_latch[0];
      while (cyc < rl + 650) begin step(); if (pad_latch[0] && !prev) rises++; prev = pad_latch[0]; end
      check_val("poll disabled no latch", rises, 32'd0);
      poll_en = 1'b1;
      run_scan("reenable", w, r_cur);
      check_val("reenable timing", r_cur - rl, 32'd800);
      check_val("reenable buttons", 32'(w), 32'h0881);

      // reset pulsed during HIGH of bit 4
      n = 0;
      while (pad_latch[0] !== 1'b1 && n < 450) begin step(); n++; end
      check_val("rst latch_start", 32'(n < 450), 32'd1);
      cnt = 0; prev = pad_clk[0];
      while (cnt < 5 && n < 600) begin step(); n++; if (pad_clk[0] && !prev) cnt++; prev = pad_clk[0]; end
      step();
      check_val("rst pre pad_clk", 32'(pad_clk), 32'h3);
      check_val("rst pre buttons", 32'(buttons), 32'h0881);
      #2 reset = 1'b1;
      #1;
      check_val("rst async pad_clk", 32'(pad_clk), 32'd0);
      check_val("rst async pad_latch", 32'(pad_latch), 32'd0);
      check_val("rst async buttons", 32'(buttons), 32'd0);
      check_val("rst async valid", 32'(valid), 32'd0);
      @(negedge clk) reset = 1'b0;
      btn0 = 8'h24; btn1 = 8'h90;
`ifdef NES_DEBOUNCE_EN
      run_scan("post_rst_first", w, r_cur);
      check_val("post_rst debounce hold", 32'(w), 32'h0000);
`endif
      run_scan("post_rst", w, r_cur);
      check_val("post_rst buttons", 32'(w), 32'h9024);

      // debounce behaviour (single-scan glitch vs held press)
      btn0 = 8'h00; btn1 = 8'h00;
      run_scan("clear_a", w, r_cur);
      run_scan("clear_b", w, r_cur);
      check_val("clear buttons", 32'(w), 32'h0000);
      btn0 = 8'h01;
      run_scan("glitch", w, r_cur);
`ifdef NES_DEBOUNCE_EN
      check_val("glitch buttons", 32'(w), 32'h0000);
`else
      check_val("glitch buttons", 32'(w), 32'h0001);
`endif
      btn0 = 8'h00;
      run_scan("glitch_gone", w, r_cur);
      check_val("glitch_gone buttons", 32'(w), 32'h0000);
      btn0 = 8'h01;
      run_scan("hold_1", w, r_cur);
`ifdef NES_DEBOUNCE_EN
      check_val("hold_1 buttons", 32'(w), 32'h0000);
`else
      check_val("hold_1 buttons", 32'(w), 32'h0001);
`endif
      run_scan("hold_2", w, r_cur);
      check_val("hold_2 buttons", 32'(w), 32'h0001);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
